// File: rtl/wallace_cpa_pipe_if.sv
// Handshake bundle for the Wallace-tree final adder.
// Upstream rows in, resolved sum out.
interface wallace_cpa_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_row;
  logic [WIDTH-1:0] carry_row;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;

  modport master (
    output in_valid, sum_row, carry_row, out_ready,
    input  in_ready, out_valid, result, cout
  );

  modport slave (
    input  in_valid, sum_row, carry_row, out_ready,
    output in_ready, out_valid, result, cout
  );
endinterface

// File: rtl/wallace_cpa_pipe.sv
// Segmented carry-propagate adder: one SW-bit add per stage,
// carry rippled stage to stage, elastic valid/ready pipeline.
module wallace_cpa_pipe #(
  parameter int WIDTH = 16,
  parameter int SEGS  = 4
) (
  input logic               clk,
  input logic               rst,
  wallace_cpa_pipe_if.slave bus
);
  localparam int SW = WIDTH / SEGS;

  logic [SEGS-1:0]  v;
  logic [SEGS-1:0]  rdy;
  logic [SEGS-1:0]  cy_a;
  logic [WIDTH-1:0] s_a [SEGS];
  logic [WIDTH-1:0] c_a [SEGS];
  logic [WIDTH-1:0] r_a [SEGS];

  // A stage may load if empty or if everything below can move.
  always_comb begin
    rdy = '0;
    rdy[SEGS-1] = !v[SEGS-1] | bus.out_ready;
    for (int k = SEGS - 2; k >= 0; k--) begin
      rdy[k] = !v[k] | rdy[k+1];
    end
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_stg
    logic [WIDTH-1:0] us, uc, ur, nres;
    logic             ucin, uv;
    logic [SW:0]      add;
    logic             vq, cyq;
    logic [WIDTH-1:0] sq, cq, rq;

    if (k == 0) begin : g_first
      assign us   = bus.sum_row;
      assign uc   = bus.carry_row;
      assign ur   = '0;
      assign ucin = 1'b0;
      assign uv   = bus.in_valid;
    end else begin : g_next
      assign us   = s_a[k-1];
      assign uc   = c_a[k-1];
      assign ur   = r_a[k-1];
      assign ucin = cy_a[k-1];
      assign uv   = v[k-1];
    end

    assign add = {1'b0, us[k*SW +: SW]}
               + {1'b0, uc[k*SW +: SW]}
               + (SW+1)'(ucin);

    always_comb begin
      nres = ur;
      nres[k*SW +: SW] = add[SW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vq  <= 1'b0;
        cyq <= 1'b0;
        sq  <= '0;
        cq  <= '0;
        rq  <= '0;
      end else if (rdy[k]) begin
        vq  <= uv;
        cyq <= add[SW];
        sq  <= us;
        cq  <= uc;
        rq  <= nres;
      end
    end

    assign v[k]    = vq;
    assign cy_a[k] = cyq;
    assign s_a[k]  = sq;
    assign c_a[k]  = cq;
    assign r_a[k]  = rq;
  end

  // The last stage's row copies have no consumer.
  logic unused_tail;
  assign unused_tail = ^{s_a[SEGS-1], c_a[SEGS-1]};

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v[SEGS-1];
  assign bus.result    = r_a[SEGS-1];
  assign bus.cout      = cy_a[SEGS-1];
endmodule
